// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - opcode/funct constants, ALU encoding and control bundle for the RV32I-subset decoder
package ctrl_pkg;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;

   localparam logic [2:0] F3_ADD = 3'b000;
   localparam logic [2:0] F3_SLL = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_SW  = 3'b010;
   localparam logic [2:0] F3_XOR = 3'b100;
   localparam logic [2:0] F3_SRL = 3'b101;
   localparam logic [2:0] F3_OR  = 3'b110;
   localparam logic [2:0] F3_AND = 3'b111;

   localparam logic [6:0] F7_ADD = 7'b0000000;
   localparam logic [6:0] F7_SUB = 7'b0100000;

   typedef logic [2:0] alu_ctrl_t;

   localparam alu_ctrl_t ALU_ADD = 3'b000;
   localparam alu_ctrl_t ALU_SUB = 3'b001;
   localparam alu_ctrl_t ALU_AND = 3'b010;
   localparam alu_ctrl_t ALU_XOR = 3'b011;
   localparam alu_ctrl_t ALU_SLL = 3'b100;
   localparam alu_ctrl_t ALU_OR  = 3'b101;
   localparam alu_ctrl_t ALU_SRL = 3'b110;

   typedef struct packed {
      logic      reg_write;
      alu_ctrl_t alu_ctrl;
      logic      mem_write;
      logic      wd_src;
      logic      imm_reg;
      logic      alu_src;
      logic      mem_to_reg;
   } ctrl_t;

   localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - maps Funct3/Funct7 to the ALU operation for R-type and I-type ALU instructions
module alu_decoder
   import ctrl_pkg::*;
(
   input  logic [2:0] funct3_i,
   input  logic [6:0] funct7_i,
   input  logic       is_rtype_i,
   output alu_ctrl_t  alu_ctrl_o,
   output logic       valid_o
);

   always_comb begin
      alu_ctrl_o = ALU_ADD;
      valid_o    = 1'b1;
      case (funct3_i)
         F3_ADD: begin
            // Funct7 only matters for R-type ADD/SUB; I-type ADDI never reads it
            if (is_rtype_i) begin
               if (funct7_i == F7_SUB)      alu_ctrl_o = ALU_SUB;
               else if (funct7_i != F7_ADD) valid_o    = 1'b0;
            end
         end
         F3_AND:  alu_ctrl_o = ALU_AND;
         F3_XOR:  alu_ctrl_o = ALU_XOR;
         F3_SLL:  alu_ctrl_o = ALU_SLL;
         F3_OR:   alu_ctrl_o = ALU_OR;
         F3_SRL:  alu_ctrl_o = ALU_SRL;
         default: valid_o    = 1'b0;
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - registered main decoder; CTRL_ILLEGAL_FLAG_EN adds the IllegalInsn output
module control_unit
   import ctrl_pkg::*;
#(
   parameter int ALU_CTRL_W = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [6:0]            Funct7,
   input  logic [2:0]            Funct3,
   input  logic [6:0]            Opcode,
   output logic                  RegWrite,
   output logic [ALU_CTRL_W-1:0] ALUControl,
   output logic                  MemWrite,
   output logic                  WDSrc,
   output logic                  ImmReg,
   output logic                  ALUSrc,
   output logic                  MemToReg
`ifdef CTRL_ILLEGAL_FLAG_EN
   ,
   output logic                  IllegalInsn
`endif
);

   alu_ctrl_t alu_ctrl;
   logic      alu_valid;
   logic      is_rtype;
   logic      illegal_d;
   ctrl_t     ctrl_dec;
   ctrl_t     ctrl_d;
   ctrl_t     ctrl_q;
`ifdef CTRL_ILLEGAL_FLAG_EN
   logic      illegal_q;
`endif

   assign is_rtype = (Opcode == OP_R);

   alu_decoder u_alu_decoder (
      .funct3_i   (Funct3),
      .funct7_i   (Funct7),
      .is_rtype_i (is_rtype),
      .alu_ctrl_o (alu_ctrl),
      .valid_o    (alu_valid)
   );

   // Each branch reads only the fields its format defines, so X elsewhere stays out
   always_comb begin
      ctrl_dec  = CTRL_NOP;
      illegal_d = 1'b0;
      case (Opcode)
         OP_R: begin
            ctrl_dec.reg_write = 1'b1;
            ctrl_dec.alu_ctrl  = alu_ctrl;
            ctrl_dec.wd_src    = 1'b1;
            ctrl_dec.alu_src   = 1'b1;
            illegal_d          = !alu_valid;
         end
         OP_IMM: begin
            ctrl_dec.reg_write = 1'b1;
            ctrl_dec.alu_ctrl  = alu_ctrl;
            ctrl_dec.wd_src    = 1'b1;
            illegal_d          = !alu_valid;
         end
         OP_LOAD: begin
            if (Funct3 == F3_LW) begin
               ctrl_dec.reg_write  = 1'b1;
               ctrl_dec.wd_src     = 1'b1;
               ctrl_dec.mem_to_reg = 1'b1;
            end else begin
               illegal_d = 1'b1;
            end
         end
         OP_STORE: begin
            if (Funct3 == F3_SW) begin
               ctrl_dec.mem_write = 1'b1;
               ctrl_dec.wd_src    = 1'b1;
               ctrl_dec.imm_reg   = 1'b1;
            end else begin
               illegal_d = 1'b1;
            end
         end
         OP_LUI: begin
            ctrl_dec.reg_write = 1'b1;
         end
         default: illegal_d = 1'b1;
      endcase
      ctrl_d = illegal_d ? CTRL_NOP : ctrl_dec;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_q    <= CTRL_NOP;
`ifdef CTRL_ILLEGAL_FLAG_EN
         illegal_q <= 1'b0;
`endif
      end else begin
         ctrl_q    <= ctrl_d;
`ifdef CTRL_ILLEGAL_FLAG_EN
         illegal_q <= illegal_d;
`endif
      end
   end

   assign RegWrite   = ctrl_q.reg_write;
   assign ALUControl = ctrl_q.alu_ctrl;
   assign MemWrite   = ctrl_q.mem_write;
   assign WDSrc      = ctrl_q.wd_src;
   assign ImmReg     = ctrl_q.imm_reg;
   assign ALUSrc     = ctrl_q.alu_src;
   assign MemToReg   = ctrl_q.mem_to_reg;
`ifdef CTRL_ILLEGAL_FLAG_EN
   assign IllegalInsn = illegal_q;
`endif

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - directed bench for control_unit; honours CTRL_ILLEGAL_FLAG_EN
module tb_control_unit;

   logic       clk;
   logic       rst_n;
   logic [6:0] Funct7;
   logic [2:0] Funct3;
   logic [6:0] Opcode;
   logic       RegWrite;
   logic [2:0] ALUControl;
   logic       MemWrite;
   logic       WDSrc;
   logic       ImmReg;
   logic       ALUSrc;
   logic       MemToReg;
`ifdef CTRL_ILLEGAL_FLAG_EN
   logic       IllegalInsn;
`endif

   int checks = 0;
   int errors = 0;

   // {RegWrite, ALUControl, MemWrite, WDSrc, ImmReg, ALUSrc, MemToReg}
   logic [9:0] obs;
   assign obs = {RegWrite, ALUControl, MemWrite, WDSrc, ImmReg, ALUSrc, MemToReg};

   localparam logic [9:0] E_ADD  = 10'b1_000_01010;
   localparam logic [9:0] E_SUB  = 10'b1_001_01010;
   localparam logic [9:0] E_AND  = 10'b1_010_01010;
   localparam logic [9:0] E_XOR  = 10'b1_011_01010;
   localparam logic [9:0] E_SLL  = 10'b1_100_01010;
   localparam logic [9:0] E_OR   = 10'b1_101_01010;
   localparam logic [9:0] E_SRL  = 10'b1_110_01010;
   localparam logic [9:0] E_SW   = 10'b0_000_11100;
   localparam logic [9:0] E_LUI  = 10'b1_000_00000;
   localparam logic [9:0] E_ADDI = 10'b1_000_01000;
   localparam logic [9:0] E_SRLI = 10'b1_110_01000;
   localparam logic [9:0] E_LW   = 10'b1_000_01001;
   localparam logic [9:0] E_ZERO = 10'b0_000_00000;

   control_unit #(.ALU_CTRL_W(3)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .Funct7     (Funct7),
      .Funct3     (Funct3),
      .Opcode     (Opcode),
      .RegWrite   (RegWrite),
      .ALUControl (ALUControl),
      .MemWrite   (MemWrite),
      .WDSrc      (WDSrc),
      .ImmReg     (ImmReg),
      .ALUSrc     (ALUSrc),
      .MemToReg   (MemToReg)
`ifdef CTRL_ILLEGAL_FLAG_EN
      ,
      .IllegalInsn(IllegalInsn)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [9:0] o, input logic [9:0] e, input logic e_ill);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s: observed=%b expected=%b", tag, o, e);
      end
`ifdef CTRL_ILLEGAL_FLAG_EN
      checks++;
      assert (IllegalInsn === e_ill) else begin
         errors++;
         $error("FAIL %s_illegal: observed=%b expected=%b", tag, IllegalInsn, e_ill);
      end
`else
      if (e_ill === 1'bx) $display("unexpected flag value in %s", tag);
`endif
   endtask

   task automatic step(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [9:0] e, input logic e_ill, input string tag);
      @(negedge clk);
      Opcode = op;
      Funct3 = f3;
      Funct7 = f7;
      @(posedge clk);
      #1;
      check(tag, obs, e, e_ill);
   endtask

   initial begin
      rst_n  = 1'b0;
      Opcode = 7'b0110011;
      Funct3 = 3'b000;
      Funct7 = 7'b0000000;
      @(posedge clk);
      #1;
      check("reset_hold", obs, E_ZERO, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("first_after_reset", obs, E_ADD, 1'b0);

      // R-type
      step(7'b0110011, 3'b000, 7'b0000000, E_ADD, 1'b0, "r_add");
      step(7'b0110011, 3'b000, 7'b0100000, E_SUB, 1'b0, "r_sub");
      step(7'b0110011, 3'b111, 7'b0000000, E_AND, 1'b0, "r_and");
      step(7'b0110011, 3'b100, 7'b0000000, E_XOR, 1'b0, "r_xor");
      step(7'b0110011, 3'b001, 7'b0100000, E_SLL, 1'b0, "r_sll_f7_ignored");
      step(7'b0110011, 3'b110, 7'bxxxxxxx, E_OR,  1'b0, "r_or_f7_x");
      step(7'b0110011, 3'b101, 7'b0000000, E_SRL, 1'b0, "r_srl");

      // Memory, LUI, I-type
      step(7'b0100011, 3'b010, 7'bxxxxxxx, E_SW,   1'b0, "sw");
      step(7'b0110111, 3'bxxx, 7'bxxxxxxx, E_LUI,  1'b0, "lui_x_fields");
      step(7'b0010011, 3'b000, 7'b0100000, E_ADDI, 1'b0, "addi_f7_ignored");
      step(7'b0010011, 3'b101, 7'b0000000, E_SRLI, 1'b0, "srli");
      step(7'b0000011, 3'b010, 7'b0000000, E_LW,   1'b0, "lw");

      // Illegal
      step(7'b1111111, 3'b000, 7'b0000000, E_ZERO, 1'b1, "illegal_opcode");
      step(7'b0110011, 3'b000, 7'b0000001, E_ZERO, 1'b1, "illegal_r_f7");
      step(7'b0110011, 3'b010, 7'b0000000, E_ZERO, 1'b1, "illegal_r_f3");
      step(7'b0000011, 3'b000, 7'b0000000, E_ZERO, 1'b1, "illegal_load_f3");
      step(7'b0100011, 3'b001, 7'b0000000, E_ZERO, 1'b1, "illegal_store_f3");
      step(7'b0010011, 3'b011, 7'b0000000, E_ZERO, 1'b1, "illegal_imm_f3");

      // Asynchronous reset mid-stream with ADD applied
      step(7'b0110011, 3'b000, 7'b0000000, E_ADD, 1'b0, "pre_reset_add");
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset", obs, E_ZERO, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_reset_add", obs, E_ADD, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
